// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - multi-cycle control sequencer for the 16-bit datapath
module datapath_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr_in,
    output logic             instr_ready,
    input  logic             mem_wait,
    output logic [31:0]      Instruction,
    output logic             RegDst,
    output logic             Branch,
    output logic             MemRead,
    output logic             MemtoReg,
    output logic             MemWrite,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic [1:0]       ALUOP,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {C_RTYPE, C_ADDI, C_LW, C_SW, C_BEQ, C_ILL} cls_t;

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [31:0]      ir_q, ir_d;
    logic             reg_dst_q, reg_dst_d;
    logic             alu_src_q, alu_src_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic [1:0]       alu_op_q, alu_op_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    cls_t             dec_cls;
    logic             dec_reg_dst, dec_alu_src, dec_mem_to_reg;
    logic [1:0]       dec_alu_op;
    logic             accept;

    always_comb begin
        dec_cls        = C_ILL;
        dec_reg_dst    = 1'b0;
        dec_alu_src    = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_alu_op     = 2'b00;
        case (instr_in[31:26])
            6'b000000: begin dec_cls = C_RTYPE; dec_reg_dst = 1'b1; dec_alu_op = 2'b10; end
            6'b001000: begin dec_cls = C_ADDI;  dec_alu_src = 1'b1; end
            6'b100011: begin dec_cls = C_LW;    dec_alu_src = 1'b1; dec_mem_to_reg = 1'b1; end
            6'b101011: begin dec_cls = C_SW;    dec_alu_src = 1'b1; end
            6'b000100: begin dec_cls = C_BEQ;   dec_alu_op = 2'b01; end
            default:   ;
        endcase
    end

    assign accept = (state_q == S_IDLE) && instr_valid;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cls_q        <= C_RTYPE;
            ir_q         <= '0;
            reg_dst_q    <= 1'b0;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_op_q     <= 2'b00;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            cls_q        <= cls_d;
            ir_q         <= ir_d;
            reg_dst_q    <= reg_dst_d;
            alu_src_q    <= alu_src_d;
            mem_to_reg_q <= mem_to_reg_d;
            alu_op_q     <= alu_op_d;
            illegal_q    <= illegal_d;
            retired_q    <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        ir_d         = ir_q;
        reg_dst_d    = reg_dst_q;
        alu_src_d    = alu_src_q;
        mem_to_reg_d = mem_to_reg_q;
        alu_op_d     = alu_op_q;
        illegal_d    = illegal_q;
        retired_d    = retired_q;
        // Static controls and IR change only on accept and hold until the next one
        if (accept) begin
            ir_d         = instr_in;
            cls_d        = dec_cls;
            reg_dst_d    = dec_reg_dst;
            alu_src_d    = dec_alu_src;
            mem_to_reg_d = dec_mem_to_reg;
            alu_op_d     = dec_alu_op;
            illegal_d    = illegal_q | (dec_cls == C_ILL);
        end
        if (done && (cls_q != C_ILL))
            retired_d = retired_q + CNT_W'(1);
        case (state_q)
            S_IDLE: if (instr_valid) state_d = S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:      state_d = S_MEM;
                    default:         state_d = S_IDLE;
                endcase
            end
            S_MEM: if (!mem_wait) state_d = (cls_q == C_LW) ? S_WB : S_IDLE;
            S_WB:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes depend only on registered state/IR class (plus mem_wait for sw done)
    always_comb begin
        instr_ready = (state_q == S_IDLE) && reset_n;
        Branch      = (state_q == S_EXEC) && (cls_q == C_BEQ);
        MemRead     = (state_q == S_MEM)  && (cls_q == C_LW);
        MemWrite    = (state_q == S_MEM)  && (cls_q == C_SW);
        RegWrite    = (state_q == S_WB);
        done        = ((state_q == S_EXEC) && ((cls_q == C_BEQ) || (cls_q == C_ILL)))
                    || (state_q == S_WB)
                    || ((state_q == S_MEM) && (cls_q == C_SW) && !mem_wait);
    end

    assign Instruction = ir_q;
    assign RegDst      = reg_dst_q;
    assign ALUSrc      = alu_src_q;
    assign MemtoReg    = mem_to_reg_q;
    assign ALUOP       = alu_op_q;
    assign illegal     = illegal_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - self-checking bench for datapath_sequencer
module tb_datapath_sequencer;

    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr_in = '0;
    logic          mem_wait = 1'b0;
    logic          instr_ready;
    logic [31:0]   Instruction;
    logic          RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
    logic [1:0]    ALUOP;
    logic          done, illegal;
    logic [CW-1:0] retired;

    datapath_sequencer #(.CNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid), .instr_in(instr_in),
        .instr_ready(instr_ready), .mem_wait(mem_wait), .Instruction(Instruction),
        .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
        .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOP(ALUOP),
        .done(done), .illegal(illegal), .retired(retired)
    );

    always #5 clock = ~clock;

    int          n_pass = 0;
    int          n_total = 0;
    int unsigned exp_retired = 0;
    logic        exp_illegal = 1'b0;

    typedef struct {
        logic [31:0] ins;
        int          waits;
        logic [4:0]  exp_static;   // {RegDst, ALUSrc, MemtoReg, ALUOP}
        int          exp_len;      // busy cycles between accept and instr_ready
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Instruction classes: 0 R, 1 addi, 2 lw, 3 sw, 4 beq, 5 illegal
    function automatic int cls_of(input logic [5:0] op);
        case (op)
            6'h00: return 0;
            6'h08: return 1;
            6'h23: return 2;
            6'h2B: return 3;
            6'h04: return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [4:0] static_of(input int c);
        case (c)
            0: return 5'b10010;
            1: return 5'b01000;
            2: return 5'b01100;
            3: return 5'b01000;
            4: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    function automatic int len_of(input int c, input int w);
        case (c)
            0, 1: return 2;
            2: return 3 + w;
            3: return 2 + w;
            default: return 1;
        endcase
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again
    task automatic run_instr(input logic [31:0] ins, input int w, input logic [4:0] exp_static,
                             input int exp_len, input string tag);
        int c;
        bit is_mem, is_wb;
        logic [5:0] exp_str;
        logic [5:0] act_str;
        c = cls_of(ins[31:26]);
        check({tag, "/ready_before"}, instr_ready, 1'b1);
        instr_valid = 1'b1;
        instr_in    = ins;
        mem_wait    = 1'($urandom_range(0, 1));
        @(negedge clock);
        instr_valid = 1'b0;
        for (int k = 0; k < exp_len; k++) begin
            instr_in = $urandom;
            is_mem = (c == 2 || c == 3) && (k >= 1) && (k <= 1 + w);
            is_wb  = ((c == 0 || c == 1) && k == 1) || (c == 2 && k == exp_len - 1);
            if (is_mem) mem_wait = (k - 1 < w);
            else        mem_wait = 1'($urandom_range(0, 1));
            #1;
            exp_str = {1'b0, is_wb, is_mem && c == 3, is_mem && c == 2, c == 4 && k == 0,
                       k == exp_len - 1};
            act_str = {instr_ready, RegWrite, MemWrite, MemRead, Branch, done};
            check($sformatf("%s/strobes_c%0d", tag, k), 32'(act_str), 32'(exp_str));
            check($sformatf("%s/static_c%0d", tag, k),
                  32'({RegDst, ALUSrc, MemtoReg, ALUOP}), 32'(exp_static));
            check($sformatf("%s/ir_c%0d", tag, k), Instruction, ins);
            @(negedge clock);
        end
        if (c == 5) exp_illegal = 1'b1;
        else        exp_retired = (exp_retired + 1) % (1 << CW);
        mem_wait = 1'b0;
        check({tag, "/ready_after"}, instr_ready, 1'b1);
        check({tag, "/retired"}, 32'(retired), exp_retired);
        check({tag, "/illegal"}, 32'(illegal), 32'(exp_illegal));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        instr_valid = 1'b0;
        mem_wait = 1'b0;
        #1;
        check("reset/outputs",
              {20'd0, instr_ready, RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc,
               RegWrite, ALUOP, done, illegal}, 32'd0);
        check("reset/ir", Instruction, 32'd0);
        check("reset/retired", 32'(retired), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_retired = 0;
        exp_illegal = 1'b0;
        @(negedge clock);
        check("reset/ready", instr_ready, 1'b1);
    endtask

    initial begin
        int bad;
        int c, w;
        logic [31:0] ins;
        logic [5:0]  op;

        vecs.push_back('{32'h00004200, 0, 5'b10010, 2});
        vecs.push_back('{32'h20084200, 0, 5'b01000, 2});
        vecs.push_back('{32'h8C084200, 2, 5'b01100, 5});
        vecs.push_back('{32'hAC084200, 0, 5'b01000, 2});
        vecs.push_back('{32'h10084200, 0, 5'b00001, 1});
        vecs.push_back('{32'hFC084200, 0, 5'b00000, 1});
        vecs.push_back('{32'h00221820, 0, 5'b10010, 2});
        vecs.push_back('{32'hAC084200, 3, 5'b01000, 5});
        vecs.push_back('{32'h8C084200, 0, 5'b01100, 3});

        @(negedge clock);
        do_reset();

        foreach (vecs[i]) run_instr(vecs[i].ins, vecs[i].waits, vecs[i].exp_static,
                                    vecs[i].exp_len, $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            c = $urandom_range(0, 5);
            case (c)
                0: op = 6'h00;
                1: op = 6'h08;
                2: op = 6'h23;
                3: op = 6'h2B;
                4: op = 6'h04;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (cls_of(op) != 5) op = 6'($urandom_range(0, 63));
                end
            endcase
            ins = {op, 26'($urandom)};
            w = $urandom_range(0, 3);
            run_instr(ins, w, static_of(c), len_of(c, w), $sformatf("rnd%0d", i));
        end

        // Reset while a write-back cycle is in progress
        instr_valid = 1'b1;
        instr_in = 32'h00004200;
        @(negedge clock);
        instr_valid = 1'b0;
        @(negedge clock);
        check("midwb/regwrite_before", RegWrite, 1'b1);
        reset_n = 1'b0;
        #1;
        check("midwb/regwrite_async", RegWrite, 1'b0);
        check("midwb/retired", 32'(retired), 32'd0);
        check("midwb/illegal", illegal, 1'b0);
        check("midwb/ir", Instruction, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        exp_retired = 0;
        exp_illegal = 1'b0;
        @(negedge clock);
        check("midwb/ready", instr_ready, 1'b1);
        check("midwb/no_regwrite", RegWrite, 1'b0);

        // Back-to-back beq with valid held high, then a legal instruction wraps retired
        bad = 0;
        instr_valid = 1'b1;
        instr_in = 32'h10084200;
        for (int i = 0; i < (1 << CW) - 1; i++) begin
            if (!instr_ready) bad++;
            @(negedge clock);
            if (!(Branch && done && !instr_ready)) bad++;
            @(negedge clock);
        end
        instr_valid = 1'b0;
        check("b2b/cadence", bad, 0);
        check("b2b/retired_full", 32'(retired), (1 << CW) - 1);
        exp_retired = (1 << CW) - 1;
        run_instr(32'h00004200, 0, 5'b10010, 2, "wrap");
        check("wrap/retired_zero", 32'(retired), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
